// File: rtl/fam_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fam_pkg : shared types, opcodes and window helpers for the       |
// |           multi-channel frequency manager                        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fam_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fam_state_t;

  localparam logic [1:0] REG_NOP   = 2'd0;
  localparam logic [1:0] REG_WRITE = 2'd2;

  function automatic logic [31:0] win_lo(input logic [31:0] clk_hz, input logic [31:0] f_hz,
                                         input logic [31:0] dev_hz);
    return clk_hz / (f_hz + dev_hz);
  endfunction

  // A target at or below the deviation has no finite upper period bound.
  function automatic logic [31:0] win_hi(input logic [31:0] clk_hz, input logic [31:0] f_hz,
                                         input logic [31:0] dev_hz);
    if (f_hz <= dev_hz) return '1;
    return clk_hz / (f_hz - dev_hz);
  endfunction

  function automatic logic [7:0] reg_num(input int unsigned c, input int unsigned f,
                                         input int unsigned freqs);
    int unsigned n;
    n = c * (freqs + 1) + f + 1;
    return n[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/frequency_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | frequency_channel : one watched pixel - period measurement,      |
// |                     bin classification and time accumulators     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module frequency_channel
  import fam_pkg::*;
#(
  parameter int                FREQS               = 2,
  parameter int                CLOCK_FREQUENCY     = 100000000,
  parameter int                FREQUENCY_DEVIATION = 40,
  parameter logic [FREQS*32-1:0] CH_FREQUENCIES    = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_run,
  input  logic                      i_strobe,
  input  logic                      i_value,
  output logic [(FREQS+1)*32-1:0]   o_acc
);

  localparam int c_BIN_W = $clog2(FREQS + 1);
  localparam logic [c_BIN_W-1:0] c_BIN_UNK = c_BIN_W'(FREQS);

  function automatic logic [FREQS*32-1:0] lo_vec();
    logic [FREQS*32-1:0] v;
    for (int f = 0; f < FREQS; f++)
      v[f*32 +: 32] = win_lo(32'(CLOCK_FREQUENCY), CH_FREQUENCIES[f*32 +: 32],
                             32'(FREQUENCY_DEVIATION));
    return v;
  endfunction

  function automatic logic [FREQS*32-1:0] hi_vec();
    logic [FREQS*32-1:0] v;
    for (int f = 0; f < FREQS; f++)
      v[f*32 +: 32] = win_hi(32'(CLOCK_FREQUENCY), CH_FREQUENCIES[f*32 +: 32],
                             32'(FREQUENCY_DEVIATION));
    return v;
  endfunction

  function automatic logic [31:0] max_hi();
    logic [FREQS*32-1:0] v;
    logic [31:0]         m;
    v = hi_vec();
    m = '0;
    for (int f = 0; f < FREQS; f++)
      if (v[f*32 +: 32] > m) m = v[f*32 +: 32];
    return m;
  endfunction

  localparam logic [FREQS*32-1:0] c_LO     = lo_vec();
  localparam logic [FREQS*32-1:0] c_HI     = hi_vec();
  localparam logic [31:0]         c_MAX_HI = max_hi();

  logic               r_sample;
  logic               r_sample_d;
  logic               r_armed;
  logic               r_bin_vld;
  logic [c_BIN_W-1:0] r_bin;
  logic [31:0]        r_period;
  logic [31:0]        r_acc [FREQS+1];
  logic               w_rise;
  logic [c_BIN_W-1:0] w_class;

  assign w_rise = r_sample & ~r_sample_d;

  // Scan downwards so the lowest-numbered matching window wins.
  always_comb begin
    w_class = c_BIN_UNK;
    for (int f = FREQS - 1; f >= 0; f--)
      if (r_period >= c_LO[f*32 +: 32] && r_period <= c_HI[f*32 +: 32])
        w_class = c_BIN_W'(f);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || i_clear) begin
      r_sample   <= 1'b0;
      r_sample_d <= 1'b0;
      r_armed    <= 1'b0;
      r_bin_vld  <= 1'b0;
      r_bin      <= '0;
      r_period   <= '0;
      for (int b = 0; b <= FREQS; b++) r_acc[b] <= '0;
    end else if (i_run) begin
      if (i_strobe) r_sample <= i_value;
      r_sample_d <= r_sample;
      // The first edge only starts a measurement; its period is meaningless.
      if (w_rise) begin
        r_period <= 32'd1;
        r_armed  <= 1'b1;
        if (r_armed) begin
          r_bin     <= w_class;
          r_bin_vld <= 1'b1;
        end
      end else begin
        if (r_period != '1) r_period <= r_period + 32'd1;
        if (r_armed && r_period > c_MAX_HI) begin
          r_bin     <= c_BIN_UNK;
          r_bin_vld <= 1'b1;
        end
      end
      for (int b = 0; b <= FREQS; b++)
        if (r_bin_vld && r_bin == c_BIN_W'(b) && r_acc[b] != '1)
          r_acc[b] <= r_acc[b] + 32'd1;
    end
  end

  for (genvar b = 0; b <= FREQS; b++) begin : g_acc_out
    assign o_acc[b*32 +: 32] = r_acc[b];
  end

endmodule
`default_nettype wire

// File: rtl/multi_channel_frequency_manager.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multi_channel_frequency_manager : per-pixel frequency binning    |
// |   with register-write drain and completion irq                   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module multi_channel_frequency_manager
  import fam_pkg::*;
#(
  parameter int                                CHANNELS            = 3,
  parameter int                                FREQS               = 2,
  parameter int                                INDEX_WIDTH         = 10,
  parameter logic [CHANNELS*INDEX_WIDTH-1:0]   PIXEL_INDICES       = {10'd1023, 10'd511, 10'd63},
  parameter logic [CHANNELS*FREQS*32-1:0]      FREQUENCIES         = {32'd30000, 32'd25000, 32'd20000,
                                                                      32'd15000, 32'd10000, 32'd5000},
  parameter int                                FREQUENCY_DEVIATION = 40,
  parameter logic [7:0]                        THRESHOLD           = 8'd192,
  parameter int                                CLOCK_FREQUENCY     = 100000000
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic [7:0]  pixel_data,
  input  logic        pixel_valid,
  input  logic        line_start,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic        irq,
  output logic [1:0]  register_operation,
  output logic [7:0]  register_number,
  output logic [31:0] register_write,
  input  logic        register_ack
);

  localparam int c_SLOTS    = FREQS + 1;
  localparam int c_NUM_REGS = CHANNELS * c_SLOTS;
  localparam int c_CH_W     = $clog2(CHANNELS + 1);
  localparam int c_F_W      = $clog2(FREQS + 1);

  if (c_NUM_REGS > 255 || CHANNELS < 1 || CHANNELS > 16 || FREQS < 1 || FREQS > 4) begin : g_param_check
    $error("multi_channel_frequency_manager: unsupported CHANNELS/FREQS combination");
  end

  fam_state_t               r_state;
  logic [INDEX_WIDTH-1:0]   r_pix_cnt;
  logic [c_CH_W-1:0]        r_ch;
  logic [c_F_W-1:0]         r_f;
  logic [INDEX_WIDTH-1:0]   w_pix_idx;
  logic                     w_run;
  logic                     w_enter_run;
  logic                     w_chan_clear;
  logic                     w_value;
  logic                     w_last;
  logic [31:0]              w_drain_val;
  logic [c_SLOTS*32-1:0]    w_ch_acc [CHANNELS];

  // Accumulators freeze on the stop cycle so the first drained value is final.
  assign w_run        = (r_state == RUN) && !stop && !clear;
  assign w_enter_run  = !clear && start && (r_state == IDLE || r_state == DONE);
  assign w_chan_clear = clear | w_enter_run;
  assign w_value      = (pixel_data >= THRESHOLD);
  assign w_pix_idx    = line_start ? '0 : r_pix_cnt;
  assign w_last       = (r_ch == c_CH_W'(CHANNELS - 1)) && (r_f == c_F_W'(FREQS));

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn)          r_pix_cnt <= '0;
    else if (w_chan_clear)         r_pix_cnt <= '0;
    else if (w_run && pixel_valid) r_pix_cnt <= w_pix_idx + 1'b1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic w_strobe;
    assign w_strobe = w_run && pixel_valid &&
                      (w_pix_idx == PIXEL_INDICES[c*INDEX_WIDTH +: INDEX_WIDTH]);

    frequency_channel #(
      .FREQS               (FREQS),
      .CLOCK_FREQUENCY     (CLOCK_FREQUENCY),
      .FREQUENCY_DEVIATION (FREQUENCY_DEVIATION),
      .CH_FREQUENCIES      (FREQUENCIES[c*FREQS*32 +: FREQS*32])
    ) u_channel (
      .clk      (s00_axi_aclk),
      .rst_n    (s00_axi_aresetn),
      .i_clear  (w_chan_clear),
      .i_run    (w_run),
      .i_strobe (w_strobe),
      .i_value  (w_value),
      .o_acc    (w_ch_acc[c])
    );
  end

  always_comb begin
    w_drain_val = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int f = 0; f < c_SLOTS; f++)
        if (r_ch == c_CH_W'(c) && r_f == c_F_W'(f))
          w_drain_val = w_ch_acc[c][f*32 +: 32];
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn || clear) begin
      r_state            <= IDLE;
      register_operation <= REG_NOP;
      register_number    <= '0;
      register_write     <= '0;
      irq                <= 1'b0;
      r_ch               <= '0;
      r_f                <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          r_ch    <= '0;
          r_f     <= '0;
        end
        RUN: if (stop) begin
          r_state            <= DRAIN;
          register_operation <= REG_WRITE;
          register_number    <= reg_num(0, 0, FREQS);
          register_write     <= w_ch_acc[0][31:0];
          r_ch               <= '0;
          r_f                <= '0;
        end
        DRAIN: begin
          // Each accepted write is followed by one NOP cycle before the next.
          if (register_operation == REG_WRITE) begin
            if (register_ack) begin
              register_operation <= REG_NOP;
              if (w_last) begin
                r_state <= DONE;
                irq     <= 1'b1;
              end else if (r_f == c_F_W'(FREQS)) begin
                r_f  <= '0;
                r_ch <= r_ch + 1'b1;
              end else begin
                r_f <= r_f + 1'b1;
              end
            end
          end else begin
            register_operation <= REG_WRITE;
            register_number    <= reg_num(32'(r_ch), 32'(r_f), FREQS);
            register_write     <= w_drain_val;
          end
        end
        DONE: if (start) begin
          r_state <= RUN;
          irq     <= 1'b0;
          r_ch    <= '0;
          r_f     <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_frequency_manager.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_multi_channel_frequency_manager : scoreboard bench, 2 ch x 2 f|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_multi_channel_frequency_manager;

  localparam int CH = 2;
  localparam int FQ = 2;
  localparam int IW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic        line_start = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        irq;
  logic [1:0]  register_operation;
  logic [7:0]  register_number;
  logic [31:0] register_write;
  logic        register_ack = 1'b0;

  multi_channel_frequency_manager #(
    .CHANNELS            (CH),
    .FREQS               (FQ),
    .INDEX_WIDTH         (IW),
    .PIXEL_INDICES       ({4'd9, 4'd0}),
    .FREQUENCIES         ({32'd20000, 32'd15000, 32'd10000, 32'd5000}),
    .FREQUENCY_DEVIATION (40),
    .THRESHOLD           (8'd192),
    .CLOCK_FREQUENCY     (1000000)
  ) dut (
    .s00_axi_aclk       (clk),
    .s00_axi_aresetn    (rst_n),
    .pixel_data         (pixel_data),
    .pixel_valid        (pixel_valid),
    .line_start         (line_start),
    .start              (start),
    .stop               (stop),
    .clear              (clear),
    .irq                (irq),
    .register_operation (register_operation),
    .register_number    (register_number),
    .register_write     (register_write),
    .register_ack       (register_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  num;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int num, input int lo, input int hi);
    exp_t e;
    e.num = 8'(num);
    e.lo  = 32'(lo);
    e.hi  = 32'(hi);
    exp_q.push_back(e);
  endtask

  // Ack responder: acts just after each rising edge once outputs settled.
  int ack_delay  = 0;
  bit ack_always = 1'b0;
  bit ack_gap    = 1'b0;
  int wait_cnt   = 0;
  always @(posedge clk) begin
    #2;
    if (register_operation == 2'd2) begin
      if (ack_always || wait_cnt >= ack_delay) begin
        register_ack = 1'b1;
        wait_cnt     = 0;
      end else begin
        register_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      wait_cnt     = 0;
      register_ack = ack_always || ack_gap;
    end
  end

  // Monitor: pops the scoreboard on every newly presented write.
  logic [1:0]  prev_op  = '0;
  logic        prev_ack = 1'b0;
  logic [7:0]  prev_num = '0;
  logic [31:0] prev_val = '0;
  bit          after_ack = 1'b0;
  int          last_ack  = -10;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_op   = '0;
      prev_ack  = 1'b0;
      after_ack = 1'b0;
    end else begin
      if (after_ack && cyc == last_ack + 1)
        chk("gap_after_ack", register_operation == 2'd0, register_operation, 0);
      if (after_ack && cyc == last_ack + 2) begin
        chk("next_write_2_after_ack", register_operation == (irq ? 2'd0 : 2'd2),
            register_operation, irq ? 0 : 2);
        after_ack = 1'b0;
      end
      if (register_operation == 2'd2 && prev_op == 2'd2 && !prev_ack) begin
        chk("hold_number", register_number == prev_num, register_number, prev_num);
        chk("hold_value", register_write == prev_val, register_write, prev_val);
      end else if (register_operation == 2'd2) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1'b0, register_number, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("write_number", register_number == e.num, register_number, e.num);
          chk("write_value", register_write >= e.lo && register_write <= e.hi,
              register_write, e.lo);
        end
      end
      if (register_operation == 2'd2 && register_ack) begin
        last_ack  = cyc;
        after_ack = 1'b1;
      end
      prev_op  = register_operation;
      prev_ack = register_ack;
      prev_num = register_number;
      prev_val = register_write;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
    end
    chk({name, "_irq_timeout"}, seen, seen, 1);
    if (seen) chk({name, "_irq_timing"}, cyc == last_ack + 1, cyc - last_ack, 1);
  endtask

  task automatic square(input int periods, input int half);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < half; i++) begin pixel_data = 8'd255; tick(); end
      for (int i = 0; i < half; i++) begin pixel_data = 8'd0;   tick(); end
    end
    pixel_data = 8'd0;
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit irq_seen;
    bit got;

    repeat (3) @(negedge clk);
    chk("reset_op", register_operation == 2'd0, register_operation, 0);
    chk("reset_num", register_number == 8'd0, register_number, 0);
    chk("reset_write", register_write == 32'd0, register_write, 0);
    chk("reset_irq", irq == 1'b0, irq, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a stalled drain.
    ack_delay = 1000;
    pulse_start();
    repeat (5) tick();
    push(1, 0, 0);
    pulse_stop();
    repeat (3) tick();
    chk("drain_entered", register_operation == 2'd2, register_operation, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_op", register_operation == 2'd0, register_operation, 0);
    chk("async_rst_num", register_number == 8'd0, register_number, 0);
    chk("async_rst_irq", irq == 1'b0, irq, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_stop();
    repeat (20) tick();
    chk("stop_in_idle_no_write", register_operation == 2'd0, register_operation, 0);

    // 200-clock period on channel 0 lands in bin 0.
    ack_delay   = 0;
    ack_always  = 1'b1;
    pixel_valid = 1'b1;
    line_start  = 1'b1;
    pixel_data  = 8'd0;
    pulse_start();
    square(10, 100);
    push(1, 1798, 1802);
    push(2, 0, 0);
    push(3, 0, 0);
    push(4, 0, 0);
    push(5, 0, 0);
    push(6, 0, 0);
    pulse_stop();
    wait_irq("period200");

    // 150-clock period falls between windows: unknown bin, slow ack.
    tick();
    ack_always = 1'b0;
    ack_delay  = 5;
    ack_gap    = 1'b1;
    pulse_start();
    chk("irq_drops_on_start", irq == 1'b0, irq, 0);
    square(5, 75);
    push(1, 0, 0);
    push(2, 0, 0);
    push(3, 598, 602);
    push(4, 0, 0);
    push(5, 0, 0);
    push(6, 0, 0);
    pulse_stop();
    wait_irq("period150");

    // clear while write 3 is pending.
    tick();
    ack_gap     = 1'b0;
    pixel_valid = 1'b0;
    line_start  = 1'b0;
    pulse_start();
    repeat (3) tick();
    push(1, 0, 0);
    push(2, 0, 0);
    push(3, 0, 0);
    pulse_stop();
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (register_operation == 2'd2 && register_number == 8'd3) got = 1'b1;
    end
    chk("write3_timeout", got, got, 1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_op", register_operation == 2'd0, register_operation, 0);
    chk("clear_num", register_number == 8'd0, register_number, 0);
    irq_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (irq) irq_seen = 1'b1;
    end
    chk("clear_irq_never", !irq_seen, irq_seen, 0);

    // start and stop together from IDLE: stop is ignored.
    tick();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    repeat (10) tick();
    chk("start_stop_same_cycle", register_operation == 2'd0, register_operation, 0);
    for (int r = 1; r <= 6; r++) push(r, 0, 0);
    pulse_stop();
    wait_irq("zero_drain");

    // stop in DONE is ignored.
    tick();
    pulse_stop();
    repeat (10) tick();
    chk("stop_in_done_op", register_operation == 2'd0, register_operation, 0);
    chk("stop_in_done_irq", irq == 1'b1, irq, 1);
    chk("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_channel_frequency_manager.md
# multi_channel_frequency_manager

Parametrised successor to the three-pixel frequency manager: watches CHANNELS pixel positions in an 8-bit pixel stream and thresholds each into a binary sample. It measures the sample's toggle period and accumulates time spent at each of FREQS target frequencies, plus an unknown bin. On stop it drains all accumulators over the axi_slave_impl register-write interface with a proper ack handshake, then raises irq. It sits between the video front end and the AXI register file; unlike its predecessor, it is fully single-clock, with no gated clocks and no FDCE enable latch.

## Interface
- CHANNELS, 3, number of watched pixels (1..16)
- FREQS, 2, target frequencies per channel (1..4)
- INDEX_WIDTH, 10, pixel counter width
- PIXEL_INDICES, {10'd1023,10'd511,10'd63}, packed CHANNELS×INDEX_WIDTH; channel c at slice c
- FREQUENCIES, {30000,25000,20000,15000,10000,5000}, packed CHANNELS×FREQS×32 Hz; slot c*FREQS+f
- FREQUENCY_DEVIATION, 40, allowed deviation in Hz
- THRESHOLD, 8'd192, sample = pixel_data >= THRESHOLD
- CLOCK_FREQUENCY, 100000000, s00_axi_aclk rate in Hz
- s00_axi_aclk  in  1  sole clock
- s00_axi_aresetn  in  1  reset, asynchronous assert, active-low
- pixel_data  in  8  pixel value
- pixel_valid  in  1  pixel_data qualifier
- line_start  in  1  first pixel of line; pixel counter forced to 0 for this beat
- start  in  1  one-cycle pulse: begin measurement
- stop  in  1  one-cycle pulse: end measurement, begin drain
- clear  in  1  level: abort to IDLE, zero all state
- irq  out  1  high in DONE
- register_operation  out  2  0 = NOP, 2 = write
- register_number  out  8  target register, 1-based
- register_write  out  32  value
- register_ack  in  1  slave accepted current write

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start → RUN; accumulators and period counters are zeroed on entry to RUN.
- RUN:
  - Pixel counter increments per pixel_valid and wraps at 2^INDEX_WIDTH.
  - Channel c samples on a valid beat with counter == its index.
  - Per-channel period counter counts clocks since the last sample rising edge and saturates at all-ones.
  - On each rising edge, period P is classified: bin f if lo_f ≤ P ≤ hi_f, where lo_f = CLOCK_FREQUENCY/(F+DEV) and hi_f = CLOCK_FREQUENCY/(F−DEV), integer division at elaboration. The lowest-numbered bin wins on overlap; otherwise the bin is unknown.
  - If the period counter exceeds the largest hi of the channel without an edge, the bin becomes unknown.
  - Before the first classified edge, the bin is none and nothing accumulates.
  - Every clock, the 32-bit accumulator of the current bin increments, saturating at 0xFFFFFFFF.
- stop in RUN → DRAIN. stop in any other state is ignored. start in RUN is ignored.
- DRAIN:
  - Register order: for c = 0..CHANNELS−1, f = 0..FREQS−1, then unknown[c].
  - Numbers run 1..CHANNELS×(FREQS+1), which must be ≤ 255 (elaboration assert).
  - Each write holds op = 2, number and value stable until a cycle with register_ack = 1.
  - The next cycle has op = 0 (one-cycle gap); the following write starts after it.
- After the last ack → DONE with irq = 1.
- DONE: start → RUN (irq drops); clear → IDLE.
- clear high in any state → IDLE next edge: all accumulators, counters and samples zero, op = 0, irq = 0. clear has priority over start and stop.
- Asynchronous reset mid-drain: immediate IDLE, outputs at reset values. A pending write is abandoned.

## Timing
- Reset values: irq 0, register_operation 0, register_number 0, register_write 0; FSM in IDLE.
- Sample register updates 1 cycle after the matching valid beat.
- Edge detect is registered, so the bin changes 2 cycles after the sampling beat.
- Accumulation starts in the cycle after the bin changes.
- First write is presented the cycle after stop is sampled.
- Write k+1 is presented 2 cycles after the ack of write k.
- irq rises the cycle after the final ack.
- ack while op = 0 is ignored.

## Structure
- Package fam_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - REG_NOP = 2'd0, REG_WRITE = 2'd2.
  - Constant functions for lo/hi window computation.
  - Register-number helper (c, f).
- Sub-module frequency_channel, instantiated CHANNELS times:
  - Inputs: sample strobe/value, run, clear.
  - Contains the period counter, classifier, and FREQS+1 accumulators.
  - Exposes the accumulator vector.
- Top level holds the pixel counter, FSM and drain multiplexer.

## Test plan
All scenarios use sim params CLOCK_FREQUENCY = 1000000, CHANNELS = 2, FREQS = 2, DEV = 40.
- Reset during RUN → all outputs 0 immediately; FSM IDLE. After release, stop alone produces no writes.
- Channel 0 toggles at a 200-clock period, F0 = 5000 (window 198..201); run 10 full periods; stop → register 1 ≈ 1800 ±2 cycles, registers 2 and 3 = 0.
- Period 150 clocks (no bin) → unknown accumulates. Register 3 nonzero; 1 and 2 = 0.
- Drain handshake: ack delayed 5 cycles per write → exactly 6 writes, numbers 1..6. Each is held until ack, with op = 0 for one cycle between writes. irq rises 1 cycle after the 6th ack.
- clear asserted mid-drain after write 2 → op = 0 next cycle, irq never rises. A following start/stop drains all zeros.
- start and stop in the same cycle from IDLE → RUN entered, stop ignored. stop in IDLE or DONE → no writes.
